// File: rtl/riscv_defs_pkg.sv
// Shared core-wide definitions: datapath widths, the canonical NOP and the default boot PC.
// Fetch, decode and execute all import this package.
package riscv_defs;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC = '0;

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between instruction memory and decode.
// Flush empties the FIFO at the clock edge and takes priority over a push in the same cycle.
module fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  output logic [W-1:0]                 data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & valid_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: entries are only visible while count_q covers them.
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // The issue logic upstream must never let a response land in a full FIFO.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      assert (!(do_push && !do_pop && count_q == CW'(DEPTH)))
        else $error("fetch_fifo: push into full FIFO");
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues fixed-latency word reads and hands {instruction, pc}
// to decode over valid/ready. Redirects flush buffered words and drop any stale response.
module instruction_fetch_unit #(
  parameter int                    XLEN     = riscv_defs::XLEN,
  parameter logic [XLEN-1:0]       RESET_PC = XLEN'(riscv_defs::RESET_PC),
  parameter int                    DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              instruction,
  output logic [XLEN-1:0]          instr_pc
);

  import riscv_defs::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_head;
  logic            fifo_valid;
  logic            pop, push, issue;
  logic [CW:0]     occupancy;

  assign pop  = fifo_valid & out_ready;
  assign push = inflight_q & ~kill_q;

  // Slots already claimed after this cycle's pop; a pop frees its slot for an issue right now.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue     = ~reset & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    kill_d        = 1'b0;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      kill_d = inflight_q;
    end else if (issue) begin
      pc_d          = pc_q + XLEN'(4);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
    end
  end

  fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (push),
    .data_i  ({inflight_pc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .valid_o (fifo_valid),
    .data_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign out_valid   = fifo_valid;
  assign instruction = fifo_valid ? fifo_head[INSTR_W-1:0] : NOP_INSTR;
  assign instr_pc    = fifo_valid ? fifo_head[FW-1:INSTR_W] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit: reset, streaming, back-pressure, redirects,
// asynchronous mid-stream reset and PC wrap-around on a second instance.
module tb_instruction_fetch_unit;

  localparam logic [31:0] MEM_XOR = 32'hA5A5_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset, rst_w;
  logic        imem_req, req_w;
  logic [63:0] imem_addr, addr_w;
  logic [31:0] imem_rdata, rdata_w;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, valid_w;
  logic        out_ready, ready_w;
  logic [31:0] instruction, instr_w;
  logic [63:0] instr_pc, ipc_w;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_w (
    .clock          (clock),
    .reset          (rst_w),
    .imem_req       (req_w),
    .imem_addr      (addr_w),
    .imem_rdata     (rdata_w),
    .redirect_valid (1'b0),
    .redirect_pc    (64'h0),
    .out_valid      (valid_w),
    .out_ready      (ready_w),
    .instruction    (instr_w),
    .instr_pc       (ipc_w)
  );

  // Instruction memory: fixed one-cycle latency, data derived from the address.
  always @(posedge clock) begin
    imem_rdata <= imem_addr[31:0] ^ MEM_XOR;
    rdata_w    <= addr_w[31:0] ^ MEM_XOR;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; rst_w = 1'b1;
    out_ready = 1'b1; ready_w = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    repeat (3) cyc();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_instr", instruction, NOP);
    chk("rst_ipc", instr_pc, 0);

    // Streaming from reset
    cyc(); reset = 1'b0; #1;
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 0);
    chk("c0_valid", out_valid, 0);
    cyc(); #1;
    chk("c1_addr", imem_addr, 4);
    chk("c1_valid", out_valid, 0);
    cyc(); #1;
    chk("c2_valid", out_valid, 1);
    chk("c2_ipc", instr_pc, 0);
    chk("c2_instr", instruction, 32'hA5A5_0000);
    chk("c2_addr", imem_addr, 8);
    cyc(); #1;
    chk("c3_ipc", instr_pc, 4);
    chk("c3_instr", instruction, 32'hA5A5_0004);
    cyc(); #1;
    chk("c4_ipc", instr_pc, 8);
    cyc(); #1;
    chk("c5_ipc", instr_pc, 12);
    chk("c5_addr", imem_addr, 20);

    // Back-pressure for six cycles
    cyc(); out_ready = 1'b0; #1;
    chk("bp_first_req", imem_req, 0);
    chk("bp_first_ipc", instr_pc, 16);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("bp_req", imem_req, 0);
      chk("bp_addr", imem_addr, 24);
      chk("bp_valid", out_valid, 1);
      chk("bp_ipc", instr_pc, 16);
    end
    cyc(); out_ready = 1'b1; #1;
    chk("res0_ipc", instr_pc, 16);
    chk("res0_req", imem_req, 1);
    chk("res0_addr", imem_addr, 24);
    cyc(); #1;
    chk("res1_ipc", instr_pc, 20);
    cyc(); #1;
    chk("res2_valid", out_valid, 1);
    chk("res2_ipc", instr_pc, 24);

    // Redirect while a request is in flight
    cyc(); redirect_valid = 1'b1; redirect_pc = 64'h100; #1;
    chk("rd_req", imem_req, 0);
    chk("rd_pop_ipc", instr_pc, 28);
    cyc(); redirect_valid = 1'b0; #1;
    chk("rd1_valid", out_valid, 0);
    chk("rd1_req", imem_req, 1);
    chk("rd1_addr", imem_addr, 64'h100);
    cyc(); #1;
    chk("rd2_valid", out_valid, 0);
    chk("rd2_addr", imem_addr, 64'h104);
    cyc(); #1;
    chk("rd3_valid", out_valid, 1);
    chk("rd3_ipc", instr_pc, 64'h100);
    chk("rd3_instr", instruction, 32'hA5A5_0100);
    out_ready = 1'b0;

    // Fill the FIFO, then reset asynchronously between edges
    cyc(); #1;
    chk("full_valid", out_valid, 1);
    chk("full_req", imem_req, 0);
    #2 reset = 1'b1; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_ipc", instr_pc, 0);
    chk("arst_instr", instruction, NOP);

    cyc(); reset = 1'b0; out_ready = 1'b1; #1;
    chk("rs0_req", imem_req, 1);
    chk("rs0_addr", imem_addr, 0);
    cyc();
    cyc(); #1;
    chk("rs2_ipc", instr_pc, 0);
    cyc(); #1;
    chk("rs3_ipc", instr_pc, 4);

    // Redirect in the same cycle as the pop of pc 0x8
    cyc(); redirect_valid = 1'b1; redirect_pc = 64'h203; #1;
    chk("rp_valid", out_valid, 1);
    chk("rp_ipc", instr_pc, 8);
    chk("rp_req", imem_req, 0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("rp1_valid", out_valid, 0);
    chk("rp1_addr", imem_addr, 64'h200);
    cyc(); #1;
    chk("rp2_valid", out_valid, 0);
    cyc(); #1;
    chk("rp3_valid", out_valid, 1);
    chk("rp3_ipc", instr_pc, 64'h200);
    chk("rp3_instr", instruction, 32'hA5A5_0200);

    // PC wrap-around on the second instance
    cyc(); rst_w = 1'b0; #1;
    chk("wr0_req", req_w, 1);
    chk("wr0_addr", addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); #1;
    chk("wr1_addr", addr_w, 0);
    chk("wr1_valid", valid_w, 0);
    cyc(); #1;
    chk("wr2_addr", addr_w, 4);
    chk("wr2_ipc", ipc_w, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr2_instr", instr_w, 32'h5A5A_FFFC);
    cyc(); #1;
    chk("wr3_ipc", ipc_w, 0);
    cyc(); #1;
    chk("wr4_ipc", ipc_w, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
